// File: rtl/zbt_frame_player_pkg.sv
// Shared constants and helpers for the ZBT frame playback path.
// Used by zbt_frame_player and zbt_player_addr_gen.
package zbt_frame_player_pkg;

   localparam int FRAME_WIDTH         = 256;
   localparam int FRAME_HEIGHT        = 192;
   localparam int SCALE_LOG2          = 2;
   localparam int NUM_FRAMES          = 20;
   localparam int ZBT_LATENCY         = 2;
   localparam int NUM_LINES_PER_FRAME = FRAME_WIDTH * FRAME_HEIGHT / 2;
   localparam int OUT_W               = FRAME_WIDTH << SCALE_LOG2;
   localparam int OUT_H               = FRAME_HEIGHT << SCALE_LOG2;

   typedef enum logic {
      SEL_IDLE,
      SEL_PENDING
   } sel_state_t;

   // 24576 = 16384 + 8192, so the frame base is two shifts and an add
   function automatic logic [18:0] frame_base_of(input logic [4:0] frame);
      logic [18:0] f;
      f = {14'd0, frame};
      return (f << 14) + (f << 13);
   endfunction

   function automatic logic [23:0] unpack_rgb(input logic [17:0] p);
      return {p[17:12], p[17:16], p[11:6], p[11:10], p[5:0], p[5:4]};
   endfunction

endpackage

// File: rtl/zbt_player_addr_gen.sv
// Maps a VGA scan position to a ZBT word address inside the current frame,
// with the half-word select and region flag registered alongside it.
module zbt_player_addr_gen
   import zbt_frame_player_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic [18:0] frame_base,
   output logic [18:0] mem_addr,
   output logic        half,
   output logic        in_region
);

   logic [7:0]  sx;
   logic [7:0]  sy;
   logic        region;
   logic [18:0] addr;

   assign sx     = hcount[SCALE_LOG2 +: 8];
   assign sy     = vcount[SCALE_LOG2 +: 8];
   assign region = enable && (hcount < 11'(OUT_W)) && (vcount < 10'(OUT_H));
   assign addr   = frame_base + 19'({sy, 7'b0}) + 19'(sx[7:1]);

   // The address only moves for visible pixels, so it parks during blanking
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_addr  <= '0;
         half      <= 1'b0;
         in_region <= 1'b0;
      end else begin
         in_region <= region;
         if (region) begin
            mem_addr <= addr;
            half     <= sx[0];
         end
      end
   end

endmodule

// File: rtl/zbt_frame_player.sv
// Plays stored 256x192 RGB666 frames from the ZBT ring, upscaled 4x to 1024x768.
// Optional macro ZBT_PLAYER_BORDER_EN draws a white border around the region.
module zbt_frame_player
   import zbt_frame_player_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        autoplay,
   input  logic        one_hz_enable,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic        frame_sel_valid,
   input  logic [4:0]  frame_sel,
   output logic        frame_sel_ready,
   output logic        sel_err,
   output logic [18:0] mem_addr,
   output logic        mem_we,
   input  logic [35:0] mem_rdata,
   output logic [23:0] pixel,
   output logic        pixel_valid,
   output logic [4:0]  cur_frame
);

   sel_state_t state, state_next;
   logic [4:0] pending_frame, pending_next;
   logic [4:0] cur_next;
   logic       tick_pending, tick_next;
   logic       err_next;
   logic       frame_start;
   logic       half;
   logic       in_region;
   logic [ZBT_LATENCY-1:0] half_sr;
   logic [ZBT_LATENCY-1:0] valid_sr;
   logic [23:0] pix_c;

   assign mem_we      = 1'b0;
   assign frame_start = (hcount == 11'd0) && (vcount == 10'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= SEL_IDLE;
         pending_frame <= '0;
         tick_pending  <= 1'b0;
         cur_frame     <= '0;
         sel_err       <= 1'b0;
      end else begin
         state         <= state_next;
         pending_frame <= pending_next;
         tick_pending  <= tick_next;
         cur_frame     <= cur_next;
         sel_err       <= err_next;
      end
   end

   // Frame changes land only on the frame-start cycle; an explicit request beats a tick
   always_comb begin
      state_next      = state;
      pending_next    = pending_frame;
      tick_next       = tick_pending;
      cur_next        = cur_frame;
      err_next        = 1'b0;
      frame_sel_ready = (state == SEL_IDLE);
      if (frame_start) begin
         if (state == SEL_PENDING) begin
            cur_next   = pending_frame;
            state_next = SEL_IDLE;
         end else if (tick_pending) begin
            cur_next = (cur_frame == 5'(NUM_FRAMES - 1)) ? 5'd0 : cur_frame + 5'd1;
         end
         tick_next = 1'b0;
      end
      if (one_hz_enable && autoplay)
         tick_next = 1'b1;
      if (frame_sel_valid && frame_sel_ready) begin
         if (frame_sel >= 5'(NUM_FRAMES)) begin
            err_next = 1'b1;
         end else begin
            pending_next = frame_sel;
            state_next   = SEL_PENDING;
         end
      end
   end

   // Feeding the next frame index lets pixel (0,0) already read the new frame
   zbt_player_addr_gen u_addr_gen (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .hcount     (hcount),
      .vcount     (vcount),
      .frame_base (frame_base_of(cur_next)),
      .mem_addr   (mem_addr),
      .half       (half),
      .in_region  (in_region)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         half_sr  <= '0;
         valid_sr <= '0;
      end else begin
         half_sr  <= {half_sr[ZBT_LATENCY-2:0], half};
         valid_sr <= {valid_sr[ZBT_LATENCY-2:0], in_region};
      end
   end

`ifdef ZBT_PLAYER_BORDER_EN
   logic [ZBT_LATENCY:0] border_sr;
   logic                 border_c;

   assign border_c = (hcount == 11'd0) || (hcount == 11'(OUT_W - 1)) ||
                     (vcount == 10'd0) || (vcount == 10'(OUT_H - 1));

   always_ff @(posedge clk) begin
      if (reset)
         border_sr <= '0;
      else
         border_sr <= {border_sr[ZBT_LATENCY-1:0], border_c};
   end

   assign pix_c = border_sr[ZBT_LATENCY] ? 24'hFFFFFF :
                  unpack_rgb(half_sr[ZBT_LATENCY-1] ? mem_rdata[17:0] : mem_rdata[35:18]);
`else
   assign pix_c = unpack_rgb(half_sr[ZBT_LATENCY-1] ? mem_rdata[17:0] : mem_rdata[35:18]);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         pixel       <= '0;
         pixel_valid <= 1'b0;
      end else if (valid_sr[ZBT_LATENCY-1]) begin
         pixel       <= pix_c;
         pixel_valid <= 1'b1;
      end else begin
         pixel       <= '0;
         pixel_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_zbt_frame_player.sv
// Directed self-checking bench for zbt_frame_player with a 2-cycle ZBT read model.
// Border expectations follow ZBT_PLAYER_BORDER_EN when the bench is built with it.
module tb_zbt_frame_player;

`ifdef ZBT_PLAYER_BORDER_EN
   localparam bit BORDER = 1'b1;
`else
   localparam bit BORDER = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        autoplay;
   logic        one_hz_enable;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        frame_sel_valid;
   logic [4:0]  frame_sel;
   logic        frame_sel_ready;
   logic        sel_err;
   logic [18:0] mem_addr;
   logic        mem_we;
   logic [35:0] mem_rdata = '0;
   logic [23:0] pixel;
   logic        pixel_valid;
   logic [4:0]  cur_frame;

   logic        override_en = 1'b0;
   logic [35:0] override_word = '0;
   logic [18:0] addr_d = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   zbt_frame_player dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .autoplay        (autoplay),
      .one_hz_enable   (one_hz_enable),
      .hcount          (hcount),
      .vcount          (vcount),
      .frame_sel_valid (frame_sel_valid),
      .frame_sel       (frame_sel),
      .frame_sel_ready (frame_sel_ready),
      .sel_err         (sel_err),
      .mem_addr        (mem_addr),
      .mem_we          (mem_we),
      .mem_rdata       (mem_rdata),
      .pixel           (pixel),
      .pixel_valid     (pixel_valid),
      .cur_frame       (cur_frame)
   );

   // Word k holds {18'(2k), 18'(2k+1)}
   function automatic logic [35:0] modelWord(input logic [18:0] a);
      logic [19:0] t;
      t = {a, 1'b0};
      return {t[17:0], t[17:1], 1'b1};
   endfunction

   function automatic logic [23:0] expPix(input int h, input int v, input logic [23:0] p);
      return (BORDER && (h == 0 || h == 1023 || v == 0 || v == 767)) ? 24'hFFFFFF : p;
   endfunction

   always @(posedge clk) begin
      addr_d    <= mem_addr;
      mem_rdata <= override_en ? override_word : modelWord(addr_d);
   end

   task automatic checkOutput(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int h, input int v);
      hcount = 11'(h);
      vcount = 10'(v);
   endtask

   // One-cycle scan position followed by a park outside the region
   task automatic runPixel(input string tag, input int h, input int v,
                           input logic [18:0] exp_addr, input logic [23:0] exp_pix,
                           input logic exp_valid);
      applyStimulus(h, v);
      @(negedge clk);
      checkOutput({tag, "_addr"}, 36'(mem_addr), 36'(exp_addr));
      applyStimulus(1024, 5);
      repeat (2) @(negedge clk);
      checkOutput({tag, "_early_valid"}, 36'(pixel_valid), 36'(0));
      @(negedge clk);
      checkOutput({tag, "_pixel"}, 36'(pixel), 36'(exp_pix));
      checkOutput({tag, "_valid"}, 36'(pixel_valid), 36'(exp_valid));
      @(negedge clk);
      checkOutput({tag, "_outside_valid"}, 36'(pixel_valid), 36'(0));
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b1;
      autoplay = 1'b0;
      one_hz_enable = 1'b0;
      frame_sel_valid = 1'b0;
      frame_sel = '0;
      applyStimulus(1024, 5);
      repeat (2) @(negedge clk);
      checkOutput("rst_addr", 36'(mem_addr), 36'(0));
      checkOutput("rst_pixel", 36'(pixel), 36'(0));
      checkOutput("rst_valid", 36'(pixel_valid), 36'(0));
      checkOutput("rst_cur", 36'(cur_frame), 36'(0));
      checkOutput("rst_ready", 36'(frame_sel_ready), 36'(1));
      checkOutput("rst_err", 36'(sel_err), 36'(0));
      checkOutput("rst_we", 36'(mem_we), 36'(0));
      reset = 1'b0;
      @(negedge clk);

      runPixel("p8_4", 8, 4, 19'd129, 24'h001008, 1'b1);
      runPixel("p12_4", 12, 4, 19'd129, 24'h00100C, 1'b1);
      runPixel("p0_10", 0, 10, 19'd256, expPix(0, 10, 24'h002000), 1'b1);
      runPixel("p1023_767", 1023, 767, 19'd24575, expPix(1023, 767, 24'h2CFFFF), 1'b1);

      enable = 1'b0;
      runPixel("disabled", 40, 40, 19'd24575, 24'h000000, 1'b0);
      enable = 1'b1;

      override_en = 1'b1;
      override_word = {18'b111111_000000_111111, 18'b000000_111111_000000};
      runPixel("unpack_h0", 8, 4, 19'd129, 24'hFF00FF, 1'b1);
      runPixel("unpack_h1", 12, 4, 19'd129, 24'h00FF00, 1'b1);
      override_word = {6'h20, 6'h15, 6'h03, 18'h00000};
      runPixel("unpack_mix", 8, 4, 19'd129, 24'h82550C, 1'b1);
      override_en = 1'b0;

      frame_sel_valid = 1'b1;
      frame_sel = 5'd7;
      @(negedge clk);
      frame_sel_valid = 1'b0;
      checkOutput("sel7_ready_low", 36'(frame_sel_ready), 36'(0));
      @(negedge clk);
      checkOutput("sel7_cur_hold", 36'(cur_frame), 36'(0));
      runPixel("sel7_start", 0, 0, 19'd172032, expPix(0, 0, 24'h510000), 1'b1);
      checkOutput("sel7_cur", 36'(cur_frame), 36'(7));
      checkOutput("sel7_ready_back", 36'(frame_sel_ready), 36'(1));

      frame_sel_valid = 1'b1;
      frame_sel = 5'd19;
      @(negedge clk);
      frame_sel_valid = 1'b0;
      runPixel("sel19_start", 0, 0, 19'd466944, expPix(0, 0, 24'h920000), 1'b1);
      checkOutput("sel19_cur", 36'(cur_frame), 36'(19));

      autoplay = 1'b1;
      one_hz_enable = 1'b1;
      @(negedge clk);
      one_hz_enable = 1'b0;
      checkOutput("tick_cur_hold", 36'(cur_frame), 36'(19));
      runPixel("tick_wrap", 0, 0, 19'd0, expPix(0, 0, 24'h000000), 1'b1);
      checkOutput("tick_wrap_cur", 36'(cur_frame), 36'(0));

      one_hz_enable = 1'b1;
      frame_sel_valid = 1'b1;
      frame_sel = 5'd3;
      @(negedge clk);
      one_hz_enable = 1'b0;
      frame_sel_valid = 1'b0;
      runPixel("both_start", 0, 0, 19'd73728, expPix(0, 0, 24'h920000), 1'b1);
      checkOutput("both_cur", 36'(cur_frame), 36'(3));
      runPixel("tick_cleared", 0, 0, 19'd73728, expPix(0, 0, 24'h920000), 1'b1);
      checkOutput("tick_cleared_cur", 36'(cur_frame), 36'(3));
      autoplay = 1'b0;

      frame_sel_valid = 1'b1;
      frame_sel = 5'd25;
      @(negedge clk);
      frame_sel_valid = 1'b0;
      checkOutput("bad_sel_err", 36'(sel_err), 36'(1));
      checkOutput("bad_sel_ready", 36'(frame_sel_ready), 36'(1));
      @(negedge clk);
      checkOutput("bad_sel_err_once", 36'(sel_err), 36'(0));
      runPixel("bad_sel_start", 0, 0, 19'd73728, expPix(0, 0, 24'h920000), 1'b1);
      checkOutput("bad_sel_cur", 36'(cur_frame), 36'(3));

      applyStimulus(500, 300);
      repeat (4) @(negedge clk);
      checkOutput("mid_valid", 36'(pixel_valid), 36'(1));
      checkOutput("mid_pixel", 36'(pixel), 36'(24'hA2B6F7));
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midrst_pixel", 36'(pixel), 36'(0));
      checkOutput("midrst_valid", 36'(pixel_valid), 36'(0));
      checkOutput("midrst_cur", 36'(cur_frame), 36'(0));
      checkOutput("midrst_addr", 36'(mem_addr), 36'(0));
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("postrst_flushed", 36'(pixel_valid), 36'(0));
      @(negedge clk);
      checkOutput("postrst_valid", 36'(pixel_valid), 36'(1));
      checkOutput("postrst_pixel", 36'(pixel), 36'(24'h10B6F7));
      checkOutput("postrst_addr", 36'(mem_addr), 36'(9662));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
